fifo_word_packer: RTL and testbench

Downstream read stage for the synchronous FIFO. It drains D_WIDTH-bit entries through the FIFO's read port (r_en / empty / data_out) and packs PACK consecutive entries, LSB-lane-first, into one wide word. The word is presented on a valid/ready output stream. A flush request emits a partial word marked with a lane-keep mask and a last flag.

---
 rtl/fifo_word_packer.sv | 130 +++++++++++++
 tb/tb_fifo_word_packer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_word_packer.sv
// Drains a synchronous FIFO read port and packs PACK entries, lane 0 first,
// into one wide word on a valid/ready stream; flush closes a partial word.
module fifo_word_packer #(
  parameter int D_WIDTH = 8,
  parameter int PACK    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fifo_empty,
  output logic                    fifo_r_en,
  input  logic [D_WIDTH-1:0]      fifo_data,
  input  logic                    flush,
  output logic [D_WIDTH*PACK-1:0] out_data,
  output logic [PACK-1:0]         out_keep,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int CW = $clog2(PACK + 1);
  localparam int OW = D_WIDTH * PACK;

  typedef enum logic {
    FILL,
    HOLD
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   lane_cnt_q, lane_cnt_d;
  logic            rd_pending_q, rd_pending_d;
  logic            flush_req_q, flush_req_d;
  logic [OW-1:0]   data_q, data_d;
  logic [PACK-1:0] keep_q, keep_d;
  logic            last_q, last_d;
  logic            valid_q, valid_d;
  logic [CW:0]     fill_lvl;

  // Lanes captured plus the one in flight; never strobe past a full word.
  assign fill_lvl = {1'b0, lane_cnt_q} + {{CW{1'b0}}, rd_pending_q};

  assign fifo_r_en = ~rst
                   & (state_q == FILL)
                   & ~fifo_empty
                   & ~flush_req_q
                   & (fill_lvl < (CW+1)'(PACK));

  assign rd_pending_d = fifo_r_en & ~fifo_empty;

  assign out_data  = data_q;
  assign out_keep  = keep_q;
  assign out_last  = last_q;
  assign out_valid = valid_q;

  always_comb begin
    state_d     = state_q;
    lane_cnt_d  = lane_cnt_q;
    data_d      = data_q;
    keep_d      = keep_q;
    last_d      = last_q;
    valid_d     = valid_q;
    flush_req_d = flush_req_q | flush;
    unique case (state_q)
      FILL: begin
        if (rd_pending_q) begin
          for (int i = 0; i < PACK; i++) begin
            if (CW'(i) == lane_cnt_q) begin
              data_d[i*D_WIDTH +: D_WIDTH] = fifo_data;
            end
          end
          lane_cnt_d = lane_cnt_q + CW'(1);
          if (lane_cnt_q == CW'(PACK - 1)) begin
            valid_d = 1'b1;
            keep_d  = '1;
            last_d  = 1'b0;
            state_d = HOLD;
          end
        end else if (flush_req_q) begin
          if (lane_cnt_q != '0) begin
            valid_d = 1'b1;
            for (int i = 0; i < PACK; i++) begin
              keep_d[i] = (CW'(i) < lane_cnt_q);
            end
            last_d  = 1'b1;
            state_d = HOLD;
          end else begin
            flush_req_d = flush;
          end
        end
      end
      HOLD: begin
        if (valid_q & out_ready) begin
          valid_d    = 1'b0;
          lane_cnt_d = '0;
          data_d     = '0;
          keep_d     = '0;
          last_d     = 1'b0;
          state_d    = FILL;
          // Only a flush-closed word consumes the pending request.
          if (last_q) begin
            flush_req_d = flush;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FILL;
      lane_cnt_q   <= '0;
      rd_pending_q <= 1'b0;
      flush_req_q  <= 1'b0;
      data_q       <= '0;
      keep_q       <= '0;
      last_q       <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_cnt_q   <= lane_cnt_d;
      rd_pending_q <= rd_pending_d;
      flush_req_q  <= flush_req_d;
      data_q       <= data_d;
      keep_q       <= keep_d;
      last_q       <= last_d;
      valid_q      <= valid_d;
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Scoreboard bench for fifo_word_packer with a behavioural FIFO read port.
// Stimulus pushes expected words; a negedge monitor pops and compares.
module tb_fifo_word_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_empty;
  logic        fifo_r_en;
  logic [7:0]  fifo_data = 8'h00;
  logic        flush = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_last;
  logic        out_valid;
  logic        out_ready = 1'b1;

  int checks = 0;
  int failures = 0;

  logic [7:0]  fq[$];
  logic [31:0] exp_data[$];
  logic [3:0]  exp_keep[$];
  logic        exp_last[$];

  always #5 clk = ~clk;

  assign fifo_empty = (fq.size() == 0);

  fifo_word_packer #(.D_WIDTH(8), .PACK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_r_en (fifo_r_en),
    .fifo_data (fifo_data),
    .flush     (flush),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // FIFO model: data_out valid the cycle after a strobe on a non-empty FIFO.
  always @(posedge clk) begin
    if (fifo_r_en && fq.size() > 0) begin
      fifo_data <= fq.pop_front();
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: pops on every accepted word; also guards the read strobe.
  always @(negedge clk) begin
    if (!rst) begin
      if (fifo_r_en && fifo_empty) begin
        failures++;
        $display("FAIL strobe_while_empty actual=1 required=0");
      end
      if (out_valid && out_ready) begin
        if (exp_data.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=%h required=none", out_data);
        end else begin
          chk("word_data", out_data, exp_data.pop_front());
          chk("word_keep", 32'(out_keep), 32'(exp_keep.pop_front()));
          chk("word_last", 32'(out_last), 32'(exp_last.pop_front()));
        end
      end
    end
  end

  task automatic push4(input logic [7:0] a, b, c, d);
    fq.push_back(a);
    fq.push_back(b);
    fq.push_back(c);
    fq.push_back(d);
  endtask

  task automatic expect_word(input logic [31:0] d, input logic [3:0] k,
                             input logic l);
    exp_data.push_back(d);
    exp_keep.push_back(k);
    exp_last.push_back(l);
  endtask

  task automatic wait_fifo_drained();
    int n;
    n = 0;
    while (fq.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (fq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL fifo_drain_timeout actual=%0d required=0", fq.size());
    end
  endtask

  task automatic wait_sb_empty();
    int n;
    n = 0;
    while (exp_data.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_data.size() != 0) begin
      failures++;
      $display("FAIL word_timeout actual=%0d required=0", exp_data.size());
    end
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  initial begin
    int n;
    int strobes;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_keep", 32'(out_keep), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    fq.push_back(8'h99);
    #1;
    chk("rst_r_en", 32'(fifo_r_en), 32'd0);
    fq.delete();
    rst = 1'b0;
    @(negedge clk);

    // Full word, count strobes.
    expect_word(32'h44332211, 4'b1111, 1'b0);
    push4(8'h11, 8'h22, 8'h33, 8'h44);
    strobes = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      if (fifo_r_en) strobes++;
    end
    chk("full_strobes", 32'(strobes), 32'd4);
    wait_sb_empty();

    // Back-pressure: word held, no strobes while 0x55 waits.
    out_ready = 1'b0;
    expect_word(32'h44332211, 4'b1111, 1'b0);
    expect_word(32'h88776655, 4'b1111, 1'b0);
    push4(8'h11, 8'h22, 8'h33, 8'h44);
    push4(8'h55, 8'h66, 8'h77, 8'h88);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", out_data, 32'h44332211);
      chk("hold_r_en", 32'(fifo_r_en), 32'd0);
    end
    chk("hold_fifo_left", 32'(fq.size()), 32'd4);
    out_ready = 1'b1;
    wait_sb_empty();

    // Flush while the second read is in flight.
    expect_word(32'h0000B2A1, 4'b0011, 1'b1);
    fq.push_back(8'hA1);
    fq.push_back(8'hB2);
    wait_fifo_drained();
    pulse_flush();
    wait_sb_empty();

    // Flush arriving with the final lane in flight: full word, no extra.
    expect_word(32'h04030201, 4'b1111, 1'b0);
    push4(8'h01, 8'h02, 8'h03, 8'h04);
    wait_fifo_drained();
    pulse_flush();
    wait_sb_empty();
    repeat (6) @(negedge clk);

    // Flush with nothing packed and FIFO empty: no output.
    pulse_flush();
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("empty_flush_quiet", 32'(n), 32'd0);
    expect_word(32'h0D0C0B0A, 4'b1111, 1'b0);
    push4(8'h0A, 8'h0B, 8'h0C, 8'h0D);
    wait_sb_empty();

    // FIFO starves mid-word, then refills.
    expect_word(32'hD4C3B2A1, 4'b1111, 1'b0);
    fq.push_back(8'hA1);
    fq.push_back(8'hB2);
    repeat (5) @(negedge clk);
    chk("starve_no_word", 32'(out_valid), 32'd0);
    fq.push_back(8'hC3);
    fq.push_back(8'hD4);
    wait_sb_empty();

    // Asynchronous reset between a strobe and its capture.
    push4(8'h31, 8'h32, 8'h33, 8'h34);
    wait_fifo_drained();
    chk("pre_rst_data", out_data, 32'h00333231);
    rst = 1'b1;
    #1;
    chk("arst_data", out_data, 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_keep", 32'(out_keep), 32'd0);
    chk("arst_r_en", 32'(fifo_r_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    expect_word(32'h45444342, 4'b1111, 1'b0);
    push4(8'h42, 8'h43, 8'h44, 8'h45);
    wait_sb_empty();
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
